// File: rtl/ifetch_unit.sv
// Instruction fetch front end: direct-mapped I-cache, next-PC prediction, JALR stall and rollback.
// Optional macro BHT_EN: 2-bit saturating-counter branch history table instead of static BTFN.
module ifetch_unit #(
  parameter int unsigned ICACHE_IDX_W = 6,
  parameter int unsigned BHT_IDX_W    = 8,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  input  logic        dec_full,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        inst_rdy,
  output logic [31:0] inst,
  output logic [31:0] inst_PC,
  output logic        pred_jump,
  input  logic        JALR_need_pause,
  input  logic        JALR_pause_rej,
  input  logic [31:0] JALR_PC,
  input  logic        br_upd_en,
  input  logic [31:0] br_upd_pc,
  input  logic        br_upd_taken
);

  localparam int unsigned Lines = 2 ** ICACHE_IDX_W;
  localparam int unsigned TagW  = 30 - ICACHE_IDX_W;

  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {StRun, StFetch, StJalrWait} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               inst_rdy_q, inst_rdy_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        inst_pc_q, inst_pc_d;
  logic               pred_q, pred_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic               cache_we;

  logic [Lines-1:0]   valid_q;
  logic [TagW-1:0]    tag_q  [Lines];
  logic [31:0]        data_q [Lines];

  logic [ICACHE_IDX_W-1:0] rd_idx, wr_idx;
  logic [TagW-1:0]         rd_tag;
  logic                    hit;
  logic [31:0]             line;
  logic [31:0]             j_imm, b_imm;
  logic                    br_taken;
  logic                    unused_in;

  assign rd_idx = pc_q[ICACHE_IDX_W+1:2];
  assign rd_tag = pc_q[31:ICACHE_IDX_W+2];
  assign wr_idx = mem_addr_q[ICACHE_IDX_W+1:2];
  assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign line   = data_q[rd_idx];
  assign j_imm  = {{12{line[31]}}, line[19:12], line[20], line[30:21], 1'b0};
  assign b_imm  = {{20{line[31]}}, line[7], line[30:25], line[11:8], 1'b0};

`ifdef BHT_EN
  logic [1:0]           bht_q [2 ** BHT_IDX_W];
  logic [BHT_IDX_W-1:0] bht_rd_idx, bht_wr_idx;

  assign bht_rd_idx = pc_q[BHT_IDX_W+1:2];
  assign bht_wr_idx = br_upd_pc[BHT_IDX_W+1:2];
  assign br_taken   = bht_q[bht_rd_idx][1];
  assign unused_in  = ^{JALR_need_pause, br_upd_pc[31:BHT_IDX_W+2], br_upd_pc[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2 ** BHT_IDX_W; i++) bht_q[i] <= 2'b01;
    end else if (rdy && br_upd_en) begin
      if (br_upd_taken && bht_q[bht_wr_idx] != 2'b11) begin
        bht_q[bht_wr_idx] <= bht_q[bht_wr_idx] + 2'd1;
      end else if (!br_upd_taken && bht_q[bht_wr_idx] != 2'b00) begin
        bht_q[bht_wr_idx] <= bht_q[bht_wr_idx] - 2'd1;
      end
    end
  end
`else
  // Static backward-taken / forward-not-taken on the B-imm sign bit.
  assign br_taken  = line[31];
  assign unused_in = ^{JALR_need_pause, br_upd_en, br_upd_taken,
                       br_upd_pc[31:BHT_IDX_W+2], br_upd_pc[BHT_IDX_W+1:0]};
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_rdy_d = 1'b0;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    pred_d     = pred_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    cache_we   = 1'b0;
    if (!rdy) begin
      inst_rdy_d = inst_rdy_q;
    end else if (rollback) begin
      pc_d      = rollback_pc;
      state_d   = StRun;
      mem_req_d = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hit) begin
            if (!dec_full) begin
              inst_rdy_d = 1'b1;
              inst_d     = line;
              inst_pc_d  = pc_q;
              pred_d     = 1'b0;
              pc_d       = pc_q + 32'd4;
              if (line[6:0] == OpJal) begin
                pc_d   = pc_q + j_imm;
                pred_d = 1'b1;
              end else if (line[6:0] == OpBranch && br_taken) begin
                pc_d   = pc_q + b_imm;
                pred_d = 1'b1;
              end else if (line[6:0] == OpJalr) begin
                // A target already resolved in the issue cycle skips the wait state.
                pc_d    = JALR_pause_rej ? JALR_PC : pc_q;
                state_d = JALR_pause_rej ? StRun : StJalrWait;
              end
            end
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {pc_q[31:2], 2'b00};
            state_d    = StFetch;
          end
        end
        StFetch: begin
          if (mem_done) begin
            cache_we  = 1'b1;
            mem_req_d = 1'b0;
            state_d   = StRun;
          end
        end
        StJalrWait: begin
          if (JALR_pause_rej) begin
            pc_d    = JALR_PC;
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      inst_rdy_q <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      pred_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_rdy_q <= inst_rdy_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      pred_q     <= pred_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if (cache_we) valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && cache_we) begin
      tag_q[wr_idx]  <= mem_addr_q[31:ICACHE_IDX_W+2];
      data_q[wr_idx] <= mem_data;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign inst_rdy  = inst_rdy_q;
  assign inst      = inst_q;
  assign inst_PC   = inst_pc_q;
  assign pred_jump = pred_q;

endmodule
